// File: rtl/ahb_timer.sv
// ahb_timer: AHB-Lite slave timer with a prescaled down-counter, one-shot/auto-reload and a level irq
// Ports: clk, rst (async, active-high); AHB-Lite slave inputs hsel, haddr, htrans, hsize, hwrite,
//        hready_in, hwdata; slave outputs hready_out, hrdata, hresp; irq = STATUS.PEND & CTRL.IE
module ahb_timer #(
    parameter int          CNT_W    = 32,
    parameter int          PRESC_W  = 8,
    parameter logic [31:0] LOAD_RST = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic        hready_in,
    input  logic [31:0] hwdata,
    output logic        hready_out,
    output logic [31:0] hrdata,
    output logic [1:0]  hresp,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
    state_t state_q, state_d;
    logic ph_q, ph_d, wr_q, wr_d;
    logic [9:0] addr_q, addr_d;
    logic en_q, en_d, ie_q, ie_d, auto_q, auto_d, pend_q, pend_d;
    logic [PRESC_W-1:0] presc_q, presc_d, pc_q, pc_d;
    logic [CNT_W-1:0] load_q, load_d, value_q, value_d;
    logic acc, ill, wr, wr_ctrl, wr_load, wr_value, wr_status, tick, uflow, unused_ok;
    logic [31:0] rd_mux;
    assign acc       = hsel & hready_in & htrans[1];
    assign ill       = (hsize != 3'b010) | (haddr[1:0] != 2'b00);
    assign wr        = ph_q & wr_q & (addr_q[9:2] == 8'd0);
    assign wr_ctrl   = wr & (addr_q[1:0] == 2'd0);
    assign wr_load   = wr & (addr_q[1:0] == 2'd1);
    assign wr_value  = wr & (addr_q[1:0] == 2'd2);
    assign wr_status = wr & (addr_q[1:0] == 2'd3);
    assign tick      = en_q & (pc_q == presc_q);
    // a software write to VALUE in the same cycle cancels this cycle's underflow entirely
    assign uflow     = tick & (value_q == '0) & ~wr_value;
    assign irq       = pend_q & ie_q;
    assign unused_ok = ^{haddr[31:12], htrans[0]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d    = (state_q == ERR1) ? ERR2 : (acc & ill) ? ERR1 : IDLE;
        hready_out = (state_q != ERR1);
        hresp      = (state_q == IDLE) ? 2'b00 : 2'b01;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            auto_q  <= 1'b0;
            presc_q <= '0;
            pc_q    <= '0;
            load_q  <= LOAD_RST[CNT_W-1:0];
            value_q <= LOAD_RST[CNT_W-1:0];
            pend_q  <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            auto_q  <= auto_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
            load_q  <= load_d;
            value_q <= value_d;
            pend_q  <= pend_d;
        end
    end
    always_comb begin
        ph_d    = acc & ~ill;
        wr_d    = acc ? hwrite : wr_q;
        addr_d  = acc ? haddr[11:2] : addr_q;
        en_d    = wr_ctrl ? hwdata[0] : (uflow & ~auto_q) ? 1'b0 : en_q;
        ie_d    = wr_ctrl ? hwdata[1] : ie_q;
        auto_d  = wr_ctrl ? hwdata[2] : auto_q;
        presc_d = wr_ctrl ? hwdata[8 +: PRESC_W] : presc_q;
        pc_d    = (~en_q | tick) ? '0 : pc_q + PRESC_W'(1);
        load_d  = wr_load ? hwdata[CNT_W-1:0] : load_q;
        value_d = wr_value ? hwdata[CNT_W-1:0] : ~tick ? value_q :
                  (value_q != '0) ? value_q - CNT_W'(1) : auto_q ? load_q : value_q;
        // a pending set wins over a simultaneous W1C
        pend_d  = uflow | (pend_q & ~(wr_status & hwdata[0]));
        rd_mux  = (addr_q[1:0] == 2'd0) ? 32'({presc_q, 5'b0, auto_q, ie_q, en_q}) :
                  (addr_q[1:0] == 2'd1) ? 32'(load_q) :
                  (addr_q[1:0] == 2'd2) ? 32'(value_q) : {31'b0, pend_q};
        hrdata  = (ph_q & ~wr_q & (addr_q[9:2] == 8'd0)) ? rd_mux : 32'h0;
    end
endmodule

// File: tb/tb_ahb_timer.sv
// tb_ahb_timer: randomized self-checking bench for ahb_timer against a register-image and period model
module tb_ahb_timer;
    logic        clk = 1'b0, rst = 1'b1, hsel = 1'b0, hwrite = 1'b0;
    logic [31:0] haddr = 32'h0, hwdata = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b010;
    logic        hready_in, hready_out, irq;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    int n_tests = 0, n_fail = 0;
    logic [31:0] q_addr[16], q_data[16], q_rd[16];
    logic        q_wr[16], q_rdy[16];
    logic [1:0]  q_resp[16];

    assign hready_in = hready_out;
    always #5 clk = ~clk;

    ahb_timer dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
        .hwrite(hwrite), .hready_in(hready_in), .hwdata(hwdata), .hready_out(hready_out),
        .hrdata(hrdata), .hresp(hresp), .irq(irq)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic op(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        q_wr[i] = w; q_addr[i] = a; q_data[i] = d;
    endtask

    task automatic bus_seq(input int n);
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            if (i < n) begin
                hsel = 1'b1; htrans = 2'b10; haddr = q_addr[i]; hwrite = q_wr[i]; hsize = 3'b010;
            end else begin
                hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
            end
            hwdata = (i > 0 && q_wr[i-1]) ? q_data[i-1] : 32'h0;
            #3;
            if (i > 0) begin
                q_rd[i-1] = hrdata; q_resp[i-1] = hresp; q_rdy[i-1] = hready_out;
            end
        end
    endtask

    task automatic wait_irq(input int lim, output int k);
        k = 0;
        while (!irq && k < lim) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic test_reset;
        op(0, 1, 32'h8, 32'h0); op(1, 1, 32'h0, 32'h3);
        bus_seq(2);
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_pre_irq got %b exp 1", irq); end
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hsize = 3'b001; hwrite = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hsize = 3'b010;
        #1;
        n_tests++; if (hready_out !== 1'b0) begin n_fail++; $display("FAIL reset_pre_err1 hready got %b exp 0", hready_out); end
        #1 rst = 1'b1;
        #1;
        n_tests++; if (hready_out !== 1'b1) begin n_fail++; $display("FAIL reset_hready got %b exp 1", hready_out); end
        n_tests++; if (hresp !== 2'b00) begin n_fail++; $display("FAIL reset_hresp got %b exp 00", hresp); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
        n_tests++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got %h exp 0", hrdata); end
        @(posedge clk); #1 rst = 1'b0;
        op(0, 0, 32'h0, 0); op(1, 0, 32'h4, 0); op(2, 0, 32'h8, 0); op(3, 0, 32'hC, 0);
        bus_seq(4);
        n_tests++; if (q_rd[0] !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h exp 0", q_rd[0]); end
        n_tests++; if (q_rd[1] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_load got %h exp ffffffff", q_rd[1]); end
        n_tests++; if (q_rd[2] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_value got %h exp ffffffff", q_rd[2]); end
        n_tests++; if (q_rd[3] !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h exp 0", q_rd[3]); end
    endtask

    task automatic test_error;
        logic [31:0] ea, ed;
        logic [2:0]  es;
        op(0, 1, 32'h0, 32'h502); op(1, 1, 32'h4, 32'h1234); op(2, 1, 32'h8, 32'h77);
        bus_seq(3);
        for (int c = 0; c < 2; c++) begin
            ea = (c == 0) ? 32'h0 : 32'h9;
            es = (c == 0) ? 3'b000 : 3'b010;
            ed = (c == 0) ? 32'hFF : 32'hDEAD;
            @(posedge clk); #1;
            hsel = 1'b1; htrans = 2'b10; haddr = ea; hsize = es; hwrite = 1'b1;
            @(posedge clk); #1;
            hsel = 1'b0; htrans = 2'b00; hsize = 3'b010; hwrite = 1'b0; hwdata = ed;
            #3;
            n_tests++; if (hready_out !== 1'b0) begin n_fail++; $display("FAIL err1_hready case%0d got %b exp 0", c, hready_out); end
            n_tests++; if (hresp !== 2'b01) begin n_fail++; $display("FAIL err1_hresp case%0d got %b exp 01", c, hresp); end
            n_tests++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL err1_hrdata case%0d got %h exp 0", c, hrdata); end
            @(posedge clk); #1;
            hsel = 1'b1; htrans = 2'b10; haddr = 32'h4; hsize = 3'b010; hwrite = 1'b0; hwdata = 32'h0;
            #3;
            n_tests++; if (hready_out !== 1'b1) begin n_fail++; $display("FAIL err2_hready case%0d got %b exp 1", c, hready_out); end
            n_tests++; if (hresp !== 2'b01) begin n_fail++; $display("FAIL err2_hresp case%0d got %b exp 01", c, hresp); end
            @(posedge clk); #1;
            hsel = 1'b0; htrans = 2'b00;
            #3;
            n_tests++; if (hresp !== 2'b00) begin n_fail++; $display("FAIL err2_next_hresp case%0d got %b exp 00", c, hresp); end
            n_tests++; if (hrdata !== 32'h1234) begin n_fail++; $display("FAIL err2_next_rdata case%0d got %h exp 1234", c, hrdata); end
        end
        op(0, 0, 32'h0, 0); op(1, 0, 32'h8, 0);
        bus_seq(2);
        n_tests++; if (q_rd[0] !== 32'h502) begin n_fail++; $display("FAIL err_ctrl_kept got %h exp 502", q_rd[0]); end
        n_tests++; if (q_rd[1] !== 32'h77) begin n_fail++; $display("FAIL err_value_kept got %h exp 77", q_rd[1]); end
    endtask

    task automatic test_oneshot(input int v, input int p);
        int k;
        op(0, 1, 32'hC, 32'h1); op(1, 1, 32'h4, v); op(2, 1, 32'h8, v); op(3, 1, 32'h0, (p << 8) | 3);
        bus_seq(4);
        @(posedge clk); #1;
        wait_irq(600, k);
        n_tests++; if (k !== (v + 1) * (p + 1)) begin n_fail++; $display("FAIL oneshot_period v=%0d p=%0d got %0d exp %0d", v, p, k, (v + 1) * (p + 1)); end
        op(0, 0, 32'h0, 0); op(1, 0, 32'h8, 0); op(2, 0, 32'hC, 0);
        bus_seq(3);
        n_tests++; if (q_rd[0] !== 32'((p << 8) | 2)) begin n_fail++; $display("FAIL oneshot_ctrl got %h exp %h", q_rd[0], (p << 8) | 2); end
        n_tests++; if (q_rd[1] !== 32'h0) begin n_fail++; $display("FAIL oneshot_value got %h exp 0", q_rd[1]); end
        n_tests++; if (q_rd[2] !== 32'h1) begin n_fail++; $display("FAIL oneshot_status got %h exp 1", q_rd[2]); end
        repeat (5) @(posedge clk);
        op(0, 0, 32'h8, 0); bus_seq(1);
        n_tests++; if (q_rd[0] !== 32'h0) begin n_fail++; $display("FAIL oneshot_value_stays got %h exp 0", q_rd[0]); end
        op(0, 1, 32'hC, 32'h1); bus_seq(1);
        @(posedge clk); #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_w1c irq got %b exp 0", irq); end
    endtask

    task automatic test_auto(input int l, input int p);
        int k, per;
        per = (l + 1) * (p + 1);
        op(0, 1, 32'hC, 32'h1); op(1, 1, 32'h4, l); op(2, 1, 32'h8, l); op(3, 1, 32'h0, (p << 8) | 7);
        bus_seq(4);
        @(posedge clk); #1;
        wait_irq(600, k);
        n_tests++; if (k !== per) begin n_fail++; $display("FAIL auto_first l=%0d p=%0d got %0d exp %0d", l, p, k, per); end
        op(0, 1, 32'hC, 32'h1); bus_seq(1);
        @(posedge clk); #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL auto_w1c irq got %b exp 0", irq); end
        wait_irq(600, k);
        n_tests++; if (k + 3 !== per) begin n_fail++; $display("FAIL auto_period l=%0d p=%0d got %0d exp %0d", l, p, k + 3, per); end
        op(0, 1, 32'h0, 32'h0); op(1, 1, 32'hC, 32'h1);
        bus_seq(2);
    endtask

    task automatic test_collision;
        op(0, 1, 32'h0, 0); op(1, 1, 32'h8, 0); op(2, 1, 32'hC, 1); bus_seq(3);
        op(0, 1, 32'h0, 3); op(1, 1, 32'h8, 32'h10); op(2, 0, 32'h8, 0); op(3, 0, 32'hC, 0); op(4, 0, 32'h0, 0);
        bus_seq(5);
        n_tests++; if (q_rd[2] !== 32'h10) begin n_fail++; $display("FAIL coll_value got %h exp 10", q_rd[2]); end
        n_tests++; if (q_rd[3] !== 32'h0) begin n_fail++; $display("FAIL coll_pend got %h exp 0", q_rd[3]); end
        n_tests++; if (q_rd[4] !== 32'h3) begin n_fail++; $display("FAIL coll_en_kept got %h exp 3", q_rd[4]); end
        op(0, 1, 32'h0, 0); op(1, 1, 32'h8, 0); op(2, 1, 32'hC, 1); bus_seq(3);
        op(0, 1, 32'h0, 3); op(1, 1, 32'hC, 1); op(2, 0, 32'hC, 0); op(3, 0, 32'h0, 0);
        bus_seq(4);
        n_tests++; if (q_rd[2] !== 32'h1) begin n_fail++; $display("FAIL coll_w1c_pend got %h exp 1", q_rd[2]); end
        n_tests++; if (q_rd[3] !== 32'h2) begin n_fail++; $display("FAIL coll_autoclear got %h exp 2", q_rd[3]); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq got %b exp 1", irq); end
        op(0, 1, 32'h0, 0); op(1, 1, 32'h8, 0); op(2, 1, 32'hC, 1); bus_seq(3);
        op(0, 1, 32'h0, 3); op(1, 1, 32'h0, 3); op(2, 0, 32'h0, 0); op(3, 0, 32'h0, 0); op(4, 0, 32'hC, 0);
        bus_seq(5);
        n_tests++; if (q_rd[2] !== 32'h3) begin n_fail++; $display("FAIL coll_ctrl_wins got %h exp 3", q_rd[2]); end
        n_tests++; if (q_rd[3] !== 32'h2) begin n_fail++; $display("FAIL coll_ctrl_later got %h exp 2", q_rd[3]); end
        n_tests++; if (q_rd[4] !== 32'h1) begin n_fail++; $display("FAIL coll_ctrl_pend got %h exp 1", q_rd[4]); end
        op(0, 1, 32'h0, 0); op(1, 1, 32'hC, 1); bus_seq(2);
    endtask

    task automatic test_back_to_back;
        logic [31:0] x;
        x = $urandom;
        op(0, 1, 32'h4, x); op(1, 0, 32'h4, 0); op(2, 0, 32'h20, 0);
        bus_seq(3);
        n_tests++; if (q_rd[1] !== x) begin n_fail++; $display("FAIL b2b_load got %h exp %h", q_rd[1], x); end
        n_tests++; if (q_rd[2] !== 32'h0) begin n_fail++; $display("FAIL b2b_unmapped got %h exp 0", q_rd[2]); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if ({q_rdy[i], q_resp[i]} !== 3'b100) begin n_fail++; $display("FAIL b2b_okay op%0d got rdy=%b resp=%b exp rdy=1 resp=00", i, q_rdy[i], q_resp[i]); end
        end
    endtask

    task automatic test_regs;
        logic [31:0] m_ctrl, m_load, m_value, a, d;
        logic [31:0] exp_rd[16];
        logic w;
        int r;
        op(0, 1, 32'h0, 0); op(1, 1, 32'h4, 0); op(2, 1, 32'h8, 0); op(3, 1, 32'hC, 1); bus_seq(4);
        m_ctrl = 0; m_load = 0; m_value = 0;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 4);
            a = (r == 4) ? 32'h10 * $urandom_range(1, 255) + 4 * $urandom_range(0, 3) : 4 * r;
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 32'h0) d = d & 32'hFFFFFFFE;
            op(i, w, a, d);
            exp_rd[i] = (a == 32'h0) ? m_ctrl : (a == 32'h4) ? m_load : (a == 32'h8) ? m_value : 32'h0;
            if (w && a == 32'h0) m_ctrl = d & 32'h0000FF07;
            if (w && a == 32'h4) m_load = d;
            if (w && a == 32'h8) m_value = d;
        end
        bus_seq(12);
        for (int i = 0; i < 12; i++) begin
            if (!q_wr[i]) begin
                n_tests++; if (q_rd[i] !== exp_rd[i]) begin n_fail++; $display("FAIL regs_rd op%0d addr %h got %h exp %h", i, q_addr[i], q_rd[i], exp_rd[i]); end
            end
        end
        op(0, 0, 32'h0, 0); op(1, 0, 32'h4, 0); op(2, 0, 32'h8, 0);
        bus_seq(3);
        n_tests++; if (q_rd[0] !== m_ctrl) begin n_fail++; $display("FAIL regs_ctrl got %h exp %h", q_rd[0], m_ctrl); end
        n_tests++; if (q_rd[1] !== m_load) begin n_fail++; $display("FAIL regs_load got %h exp %h", q_rd[1], m_load); end
        n_tests++; if (q_rd[2] !== m_value) begin n_fail++; $display("FAIL regs_value got %h exp %h", q_rd[2], m_value); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_error;
        test_oneshot(3, 0);
        test_auto(1, 2);
        for (int i = 0; i < 3; i++) test_oneshot($urandom_range(0, 6), $urandom_range(0, 3));
        for (int i = 0; i < 2; i++) test_auto($urandom_range(1, 4), $urandom_range(1, 2));
        test_collision;
        test_back_to_back;
        test_regs;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
